// File: rtl/instr_align_if.sv
// Fetch-side and decode-side signal bundle for the instruction-align stage.
// master = surrounding pipeline (IF + decode), slave = instr_align.
interface instr_align_if;
  logic        i_flush;
  logic        i_stall;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [15:0] i_data0;
  logic [15:0] i_data1;
  logic        i_except_valid;
  logic [3:0]  i_except_code;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_compressed;
  logic        o_except_valid;
  logic [3:0]  o_except_code;

  modport master (
    output i_flush, i_stall, i_valid, i_pc, i_data0, i_data1, i_except_valid, i_except_code,
    input  o_stall, o_valid, o_pc, o_instr, o_compressed, o_except_valid, o_except_code
  );

  modport slave (
    input  i_flush, i_stall, i_valid, i_pc, i_data0, i_data1, i_except_valid, i_except_code,
    output o_stall, o_valid, o_pc, o_instr, o_compressed, o_except_valid, o_except_code
  );
endinterface

// File: rtl/instr_align.sv
// Instruction-align stage: turns fetch words into one aligned instruction per cycle.
// IA_RVC_EN enables compressed support via a 4-entry halfword queue; otherwise 32-bit only.
module instr_align (
  input logic          i_clk,
  input logic          i_rst_n,
  instr_align_if.slave bus
);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        cmp;
    logic        exc;
    logic [3:0]  code;
  } out_t;

  out_t        oq;
  logic        emit;
  logic [31:0] e_pc;
  logic [31:0] e_instr;
  logic        e_cmp;
  logic        e_exc;
  logic [3:0]  e_code;
  logic        accept;

`ifdef IA_RVC_EN
  typedef struct packed {
    logic [15:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  code;
  } hw_t;

  localparam int QD = 4;
  localparam int SD = 6;

  hw_t        q     [QD];
  hw_t        q_n   [QD];
  hw_t        inc   [2];
  hw_t        str   [SD];
  logic [2:0] count;
  logic [2:0] count_n;
  logic [2:0] s_cnt;
  logic [1:0] n_in;
  logic [1:0] n_cons;

  // Stall is derived from the registered count only, keeping i_valid off the path.
  assign bus.o_stall = bus.i_stall | (count > 3'd2);
  assign accept      = bus.i_valid & ~bus.o_stall;

  // Halfwords contributed by this cycle's fetch word.
  always_comb begin
    inc[0] = '0;
    inc[1] = '0;
    n_in   = 2'd0;
    if (accept) begin
      if (bus.i_except_valid) begin
        inc[0] = {16'h0, bus.i_pc, 1'b1, bus.i_except_code};
        n_in   = 2'd1;
      end else if (!bus.i_pc[1]) begin
        inc[0] = {bus.i_data0, bus.i_pc, 1'b0, 4'h0};
        inc[1] = {bus.i_data1, bus.i_pc + 32'd2, 1'b0, 4'h0};
        n_in   = 2'd2;
      end else begin
        inc[0] = {bus.i_data1, bus.i_pc, 1'b0, 4'h0};
        n_in   = 2'd1;
      end
    end
  end

  // Effective stream: queued entries followed by the bypassed incoming halves.
  always_comb begin
    for (int i = 0; i < SD; i++) str[i] = '0;
    for (int i = 0; i < QD; i++) if (3'(i) < count) str[i] = q[i];
    if (n_in != 2'd0) str[count]         = inc[0];
    if (n_in == 2'd2) str[count + 3'd1]  = inc[1];
    s_cnt = count + {1'b0, n_in};
  end

  always_comb begin
    emit    = 1'b0;
    n_cons  = 2'd0;
    e_pc    = '0;
    e_instr = '0;
    e_cmp   = 1'b0;
    e_exc   = 1'b0;
    e_code  = '0;
    if (s_cnt != 3'd0) begin
      if (str[0].exc) begin
        emit   = 1'b1;
        n_cons = 2'd1;
        e_pc   = str[0].pc;
        e_exc  = 1'b1;
        e_code = str[0].code;
      end else if (str[0].data[1:0] != 2'b11) begin
        emit    = 1'b1;
        n_cons  = 2'd1;
        e_pc    = str[0].pc;
        e_instr = {16'h0, str[0].data};
        e_cmp   = 1'b1;
      end else if (s_cnt >= 3'd2) begin
        // 32-bit: a faulting upper half turns the whole instruction into an exception.
        emit   = 1'b1;
        n_cons = 2'd2;
        e_pc   = str[0].pc;
        if (str[1].exc) begin
          e_exc  = 1'b1;
          e_code = str[1].code;
        end else begin
          e_instr = {str[1].data, str[0].data};
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < QD; i++) q_n[i] = str[3'(i) + {1'b0, n_cons}];
    count_n = s_cnt - {1'b0, n_cons};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_flush) begin
      count <= 3'd0;
    end else if (!bus.i_stall) begin
      count <= count_n;
      q     <= q_n;
    end
  end

`else
  // No compressed support: each accepted word is one instruction or an exception.
  assign bus.o_stall = bus.i_stall;
  assign accept      = bus.i_valid & ~bus.i_stall;

  always_comb begin
    emit    = 1'b0;
    e_pc    = '0;
    e_instr = '0;
    e_cmp   = 1'b0;
    e_exc   = 1'b0;
    e_code  = '0;
    if (accept) begin
      emit = 1'b1;
      e_pc = bus.i_pc;
      if (bus.i_except_valid) begin
        e_exc  = 1'b1;
        e_code = bus.i_except_code;
      end else if (bus.i_pc[1]) begin
        e_exc  = 1'b1;
        e_code = 4'h0;
      end else begin
        e_instr = {bus.i_data1, bus.i_data0};
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_flush) begin
      oq <= '0;
    end else if (!bus.i_stall) begin
      oq <= {emit, e_pc, e_instr, e_cmp, e_exc, e_code};
    end
  end

  assign bus.o_valid        = oq.v;
  assign bus.o_pc           = oq.pc;
  assign bus.o_instr        = oq.instr;
  assign bus.o_compressed   = oq.cmp;
  assign bus.o_except_valid = oq.exc;
  assign bus.o_except_code  = oq.code;

endmodule

// File: tb/tb_instr_align.sv
// Directed bench for instr_align; covers both the IA_RVC_EN and 32-bit-only builds.
module tb_instr_align;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
    logic        ev;
    logic [3:0]  ec;
  } ob_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  ob_t  exp_o;

  instr_align_if bus ();

  instr_align dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic ob_t obs();
    return {bus.o_valid, bus.o_pc, bus.o_instr, bus.o_compressed, bus.o_except_valid, bus.o_except_code};
  endfunction

  function automatic ob_t mk(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic c, input logic ev, input logic [3:0] ec);
    return {v, pc, ins, c, ev, ec};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [15:0] d0, input logic [15:0] d1,
                       input logic ev, input logic [3:0] ec);
    bus.i_valid        = 1'b1;
    bus.i_pc           = pc;
    bus.i_data0        = d0;
    bus.i_data1        = d1;
    bus.i_except_valid = ev;
    bus.i_except_code  = ec;
  endtask

  task automatic idle();
    bus.i_valid        = 1'b0;
    bus.i_pc           = '0;
    bus.i_data0        = '0;
    bus.i_data1        = '0;
    bus.i_except_valid = 1'b0;
    bus.i_except_code  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.i_flush = 1'b0; bus.i_stall = 1'b1; idle();
    tick(); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL reset_out got %h want %h", obs(), exp_o); end
    n_cmp++;
    if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall_hi got %b want 1", bus.o_stall); end
    bus.i_stall = 1'b0; #1;
    n_cmp++;
    if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall_lo got %b want 0", bus.o_stall); end
    rst_n = 1'b1;
  endtask

`ifdef IA_RVC_EN
  task automatic test_two_compressed();
    drive(32'h1000, 16'h4501, 16'h4585, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h1000, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL two_c_first got %h want %h", obs(), exp_o); end
    n_cmp++;
    if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL two_c_stall got %b want 0", bus.o_stall); end
    idle(); tick();
    exp_o = mk(1, 32'h1002, 32'h4585, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL two_c_second got %h want %h", obs(), exp_o); end
    tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL two_c_drain got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_straddle();
    drive(32'h2000, 16'h4501, 16'h0513, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h2000, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL strad_c got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL strad_wait got %h want %h", obs(), exp_o); end
    drive(32'h2004, 16'h00a0, 16'h4585, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h2002, 32'h00a00513, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL strad_32 got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(1, 32'h2006, 32'h4585, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL strad_tail got %h want %h", obs(), exp_o); end
    tick();
  endtask

  task automatic test_odd_entry();
    drive(32'h3002, 16'hffff, 16'h4501, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h3002, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL odd_first got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL odd_nothing got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_exception();
    drive(32'h4000, 16'h1234, 16'h5678, 1'b1, 4'hc); tick();
    exp_o = mk(1, 32'h4000, 0, 0, 1, 4'hc); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL exc_plain got %h want %h", obs(), exp_o); end
    drive(32'h3ffc, 16'h4501, 16'h0513, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h3ffc, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL exc_pre got %h want %h", obs(), exp_o); end
    drive(32'h4000, 16'hdead, 16'hbeef, 1'b1, 4'hc); tick();
    exp_o = mk(1, 32'h3ffe, 0, 0, 1, 4'hc); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL exc_strad got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL exc_drain got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_flush();
    drive(32'h5000, 16'h4501, 16'h0513, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h5000, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_pre got %h want %h", obs(), exp_o); end
    idle(); bus.i_flush = 1'b1; tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_out got %h want %h", obs(), exp_o); end
    bus.i_flush = 1'b0;
    drive(32'h6000, 16'h4501, 16'h4585, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h6000, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_new0 got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(1, 32'h6002, 32'h4585, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_new1 got %h want %h", obs(), exp_o); end
    bus.i_flush = 1'b1;
    drive(32'h7000, 16'h4501, 16'h4585, 1'b0, 4'h0); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_drop0 got %h want %h", obs(), exp_o); end
    bus.i_flush = 1'b0; idle(); tick();
    n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_drop1 got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_stall();
    drive(32'h8000, 16'h4501, 16'h4585, 1'b0, 4'h0); tick();
    bus.i_stall = 1'b1;
    drive(32'h8004, 16'h4501, 16'h4585, 1'b0, 4'h0); #1;
    n_cmp++;
    if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL stall_ostall got %b want 1", bus.o_stall); end
    exp_o = mk(1, 32'h8000, 32'h4501, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); n_cmp++;
      if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_hold%0d got %h want %h", k, obs(), exp_o); end
      n_cmp++;
      if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL stall_hold_os%0d got %b want 1", k, bus.o_stall); end
    end
    bus.i_stall = 1'b0; tick();
    exp_o = mk(1, 32'h8002, 32'h4585, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_rel0 got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(1, 32'h8004, 32'h4501, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_rel1 got %h want %h", obs(), exp_o); end
    tick();
    exp_o = mk(1, 32'h8006, 32'h4585, 1, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_rel2 got %h want %h", obs(), exp_o); end
    tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_drain got %h want %h", obs(), exp_o); end
  endtask

  // IF advances only when a word was accepted: w0,w1,w2 then w3 is held through the throttle.
  task automatic test_back_to_back();
    int   sched [8] = '{0, 1, 2, 3, 3, -1, -1, -1};
    logic os_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] wpc;
    for (int e = 0; e < 8; e++) begin
      if (sched[e] >= 0) begin
        wpc = 32'h9000 + 32'(4 * sched[e]);
        drive(wpc, 16'(16'h4401 + 8 * sched[e]), 16'(16'h4405 + 8 * sched[e]), 1'b0, 4'h0);
      end else begin
        idle();
      end
      tick();
      exp_o = mk(1, 32'h9000 + 32'(2 * e), 32'h4401 + 32'(4 * e), 1, 0, 0); n_cmp++;
      if (obs() !== exp_o) begin n_bad++; $display("FAIL b2b_out%0d got %h want %h", e, obs(), exp_o); end
      n_cmp++;
      if (bus.o_stall !== os_exp[e]) begin n_bad++; $display("FAIL b2b_stall%0d got %b want %b", e, bus.o_stall, os_exp[e]); end
    end
    tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL b2b_drain got %h want %h", obs(), exp_o); end
  endtask

`else
  task automatic test_word();
    drive(32'h1000, 16'h0513, 16'h00a0, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h1000, 32'h00a00513, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL word0 got %h want %h", obs(), exp_o); end
    n_cmp++;
    if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL word_stall got %b want 0", bus.o_stall); end
    drive(32'h1004, 16'h0293, 16'h0010, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h1004, 32'h00100293, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL word1 got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL word_idle got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_exception();
    drive(32'h3002, 16'hffff, 16'h4501, 1'b0, 4'h0); tick();
    exp_o = mk(1, 32'h3002, 0, 0, 1, 4'h0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL misalign got %h want %h", obs(), exp_o); end
    drive(32'h4000, 16'h1234, 16'h5678, 1'b1, 4'hc); tick();
    exp_o = mk(1, 32'h4000, 0, 0, 1, 4'hc); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL exc_plain got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_flush();
    bus.i_flush = 1'b1;
    drive(32'h7000, 16'h0513, 16'h00a0, 1'b0, 4'h0); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_drop got %h want %h", obs(), exp_o); end
    bus.i_flush = 1'b0; idle(); tick();
    n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL flush_after got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_stall();
    drive(32'h8000, 16'h0513, 16'h00a0, 1'b0, 4'h0); tick();
    bus.i_stall = 1'b1;
    drive(32'h8004, 16'h0293, 16'h0010, 1'b0, 4'h0); #1;
    n_cmp++;
    if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL stall_ostall got %b want 1", bus.o_stall); end
    exp_o = mk(1, 32'h8000, 32'h00a00513, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); n_cmp++;
      if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_hold%0d got %h want %h", k, obs(), exp_o); end
    end
    bus.i_stall = 1'b0; tick();
    exp_o = mk(1, 32'h8004, 32'h00100293, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_rel got %h want %h", obs(), exp_o); end
    idle(); tick();
    exp_o = mk(0, 0, 0, 0, 0, 0); n_cmp++;
    if (obs() !== exp_o) begin n_bad++; $display("FAIL stall_drain got %h want %h", obs(), exp_o); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
`ifdef IA_RVC_EN
    test_two_compressed();
    test_straddle();
    test_odd_entry();
    test_exception();
    test_flush();
    test_stall();
    test_back_to_back();
`else
    test_word();
    test_exception();
    test_flush();
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
